// File: rtl/shift_sub_divider.sv
`default_nettype none
// ============================================================================
// Module   : shift_sub_divider
// Purpose  : Sequential restoring divider with an integrated controller FSM.
//            One shift/subtract/restore iteration per clock. It returns the
//            quotient, the remainder and a divide-by-zero flag, then pulses
//            done for one cycle.
// Options  : SHIFT_SUB_SIGNED_EN - when defined, the operands are two's
//            complement and the division truncates toward zero. When it is
//            not defined, the divider is purely unsigned.
// Ports    : clk            - system clock (rising edge)
//            rst_n          - asynchronous active-low reset
//            start          - division request, sampled only when idle
//            dividend_in    - WIDTH-bit dividend
//            divisor_in     - WIDTH-bit divisor
//            busy           - high while an operation is in RUN or DONE
//            done           - one-cycle pulse when the results are valid
//            div_by_zero    - the last operation had a zero divisor
//            quotient_out   - quotient of the last operation
//            remainder_out  - remainder of the last operation
// Revision : 1.0 - initial release
// ============================================================================
module shift_sub_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend_in,
  input  logic [WIDTH-1:0] divisor_in,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] quotient_out,
  output logic [WIDTH-1:0] remainder_out
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH:0]   r_a;       // partial remainder, top bit is the sign
  logic [WIDTH-1:0] r_q;       // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] r_m;       // divisor
  logic [CW-1:0]    r_count;
  logic             r_done;
  logic             r_dbz;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;

  // One iteration. The subtraction is one bit wider than A, so A's own sign
  // bit takes part in it and the borrow lands in the top bit.
  logic [WIDTH+1:0] w_shift;
  logic [WIDTH+1:0] w_diff;
  logic             w_neg;
  logic [WIDTH:0]   w_next_a;
  logic [WIDTH-1:0] w_next_q;

  assign w_shift  = {r_a, r_q[WIDTH-1]};
  assign w_diff   = w_shift - {2'b00, r_m};
  assign w_neg    = w_diff[WIDTH+1];
  assign w_next_a = w_neg ? w_shift[WIDTH:0] : w_diff[WIDTH:0];
  assign w_next_q = {r_q[WIDTH-2:0], ~w_neg};

  // The core always divides magnitudes. The signed build corrects the signs
  // while the results are latched, so the latency does not change.
  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dvs_mag;
  logic [WIDTH-1:0] w_q_res;
  logic [WIDTH-1:0] w_r_res;

`ifdef SHIFT_SUB_SIGNED_EN
  logic r_neg_q;   // operand signs differ
  logic r_neg_r;   // dividend was negative

  // The magnitude of the most-negative value wraps to 2^(WIDTH-1). That value
  // is still correct when it is read as unsigned.
  always_comb begin
    w_dvd_mag = dividend_in[WIDTH-1] ? -dividend_in : dividend_in;
    w_dvs_mag = divisor_in[WIDTH-1]  ? -divisor_in  : divisor_in;
    w_q_res   = r_neg_q ? -w_next_q : w_next_q;
    w_r_res   = r_neg_r ? -w_next_a[WIDTH-1:0] : w_next_a[WIDTH-1:0];
  end
`else
  always_comb begin
    w_dvd_mag = dividend_in;
    w_dvs_mag = divisor_in;
    w_q_res   = w_next_q;
    w_r_res   = w_next_a[WIDTH-1:0];
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_q     <= '0;
      r_m     <= '0;
      r_count <= '0;
      r_done  <= 1'b0;
      r_dbz   <= 1'b0;
      r_quot  <= '0;
      r_rem   <= '0;
`ifdef SHIFT_SUB_SIGNED_EN
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (divisor_in == '0) begin
              // Zero divisor: the results are fixed, so skip the iterations.
              r_quot  <= '1;
              r_rem   <= dividend_in;
              r_dbz   <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_m     <= w_dvs_mag;
              r_q     <= w_dvd_mag;
              r_a     <= '0;
              r_count <= CW'(WIDTH);
              r_dbz   <= 1'b0;
`ifdef SHIFT_SUB_SIGNED_EN
              r_neg_q <= dividend_in[WIDTH-1] ^ divisor_in[WIDTH-1];
              r_neg_r <= dividend_in[WIDTH-1];
`endif
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          r_a     <= w_next_a;
          r_q     <= w_next_q;
          r_count <= r_count - 1'b1;
          if (r_count == CW'(1)) begin
            r_quot  <= w_q_res;
            r_rem   <= w_r_res;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy          = (r_state != S_IDLE);
  assign done          = r_done;
  assign div_by_zero   = r_dbz;
  assign quotient_out  = r_quot;
  assign remainder_out = r_rem;

endmodule
`default_nettype wire

// File: tb/tb_shift_sub_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_sub_divider
// Purpose  : Directed self-checking bench for shift_sub_divider (WIDTH=4).
//            The default build runs the unsigned scenarios. When
//            SHIFT_SUB_SIGNED_EN is defined, it runs the signed scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_sub_divider;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] dividend_in;
  logic [3:0] divisor_in;
  logic       busy;
  logic       done;
  logic       div_by_zero;
  logic [3:0] quotient_out;
  logic [3:0] remainder_out;

  int n_checks;
  int n_pass;

  shift_sub_divider #(.WIDTH(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .dividend_in   (dividend_in),
    .divisor_in    (divisor_in),
    .busy          (busy),
    .done          (done),
    .div_by_zero   (div_by_zero),
    .quotient_out  (quotient_out),
    .remainder_out (remainder_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Launch one operation. lat counts the cycles after the accepting edge
  // until done is seen high, or is -1 if done never comes.
  task automatic run_div(input logic [3:0] dvd, input logic [3:0] dvs,
                         output logic [3:0] q, output logic [3:0] r,
                         output logic z, output int lat);
    @(negedge clk);
    dividend_in = dvd;
    divisor_in  = dvs;
    start       = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = k;
        break;
      end
    end
    q = quotient_out;
    r = remainder_out;
    z = div_by_zero;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    dividend_in = '0;
    divisor_in  = '0;
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else n_pass++;
    n_checks++; if (div_by_zero !== 1'b0) $display("FAIL reset_dbz got %b want 0", div_by_zero); else n_pass++;
    n_checks++; if (quotient_out !== 4'd0) $display("FAIL reset_q got %h want 0", quotient_out); else n_pass++;
    n_checks++; if (remainder_out !== 4'd0) $display("FAIL reset_r got %h want 0", remainder_out); else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

`ifndef SHIFT_SUB_SIGNED_EN
  task automatic test_basic;
    int lat;
    @(negedge clk);
    dividend_in = 4'd13;
    divisor_in  = 4'd3;
    start       = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b1) $display("FAIL basic_busy got %b want 1", busy); else n_pass++;
    lat = -1;
    if (done === 1'b1) lat = 0;
    for (int k = 1; k < 20 && lat < 0; k++) begin
      @(negedge clk);
      if (done === 1'b1) lat = k;
    end
    n_checks++; if (lat != 5) $display("FAIL basic_latency got %0d want 5", lat); else n_pass++;
    n_checks++; if (quotient_out !== 4'd4) $display("FAIL basic_q got %0d want 4", quotient_out); else n_pass++;
    n_checks++; if (remainder_out !== 4'd1) $display("FAIL basic_r got %0d want 1", remainder_out); else n_pass++;
    n_checks++; if (div_by_zero !== 1'b0) $display("FAIL basic_dbz got %b want 0", div_by_zero); else n_pass++;
  endtask

  task automatic test_boundary;
    logic [3:0] vd [4] = '{4'd15, 4'd3, 4'd0, 4'd15};
    logic [3:0] vs [4] = '{4'd1,  4'd7, 4'd5, 4'd15};
    logic [3:0] eq [4] = '{4'd15, 4'd0, 4'd0, 4'd1};
    logic [3:0] er [4] = '{4'd0,  4'd3, 4'd0, 4'd0};
    logic [3:0] q, r;
    logic z;
    int lat;
    for (int i = 0; i < 4; i++) begin
      run_div(vd[i], vs[i], q, r, z, lat);
      n_checks++;
      if (lat != 5 || q !== eq[i] || r !== er[i])
        $display("FAIL boundary_%0d/%0d got q=%0d r=%0d lat=%0d want q=%0d r=%0d lat=5",
                 vd[i], vs[i], q, r, lat, eq[i], er[i]);
      else n_pass++;
    end
  endtask

  task automatic test_sweep;
    logic [3:0] q, r;
    logic z;
    int lat;
    for (int a = 0; a < 16; a++) begin
      for (int b = 1; b < 16; b++) begin
        run_div(4'(a), 4'(b), q, r, z, lat);
        n_checks++;
        if (lat != 5 || (int'(q) * b + int'(r)) != a || int'(r) >= b || z !== 1'b0)
          $display("FAIL sweep_%0d/%0d got q=%0d r=%0d z=%b lat=%0d want q*d+r=%0d r<d z=0",
                   a, b, q, r, z, lat, a);
        else n_pass++;
      end
    end
  endtask

  task automatic test_div_zero;
    logic [3:0] q, r;
    logic z;
    int lat;
    run_div(4'd9, 4'd0, q, r, z, lat);
    n_checks++; if (lat != 1) $display("FAIL dz_latency got %0d want 1", lat); else n_pass++;
    n_checks++; if (q !== 4'hF) $display("FAIL dz_q got %h want f", q); else n_pass++;
    n_checks++; if (r !== 4'd9) $display("FAIL dz_r got %0d want 9", r); else n_pass++;
    n_checks++; if (z !== 1'b1) $display("FAIL dz_flag got %b want 1", z); else n_pass++;
    run_div(4'd8, 4'd2, q, r, z, lat);
    n_checks++; if (z !== 1'b0) $display("FAIL dz_clear got %b want 0", z); else n_pass++;
    n_checks++;
    if (lat != 5 || q !== 4'd4 || r !== 4'd0)
      $display("FAIL dz_after got q=%0d r=%0d lat=%0d want q=4 r=0 lat=5", q, r, lat);
    else n_pass++;
  endtask

  task automatic test_busy_collision;
    int ndone;
    logic [3:0] q, r;
    ndone = 0;
    q = 'x;
    r = 'x;
    @(negedge clk);
    dividend_in = 4'd14;
    divisor_in  = 4'd4;
    start       = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1;
    start       = 1'b1;
    dividend_in = 4'd1;
    divisor_in  = 4'd1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (ndone == 0) begin
          q = quotient_out;
          r = remainder_out;
        end
        ndone++;
      end
    end
    n_checks++; if (ndone != 1) $display("FAIL collision_done_count got %0d want 1", ndone); else n_pass++;
    n_checks++; if (q !== 4'd3) $display("FAIL collision_q got %0d want 3", q); else n_pass++;
    n_checks++; if (r !== 4'd2) $display("FAIL collision_r got %0d want 2", r); else n_pass++;
  endtask

  task automatic test_reset_mid;
    logic [3:0] q, r;
    logic z;
    int lat;
    @(negedge clk);
    dividend_in = 4'd12;
    divisor_in  = 4'd5;
    start       = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0 ||
        quotient_out !== 4'd0 || remainder_out !== 4'd0)
      $display("FAIL midreset_outputs got busy=%b done=%b z=%b q=%0d r=%0d want all 0",
               busy, done, div_by_zero, quotient_out, remainder_out);
    else n_pass++;
    repeat (2) @(negedge clk);
    n_checks++; if (done !== 1'b0) $display("FAIL midreset_nodone got %b want 0", done); else n_pass++;
    rst_n = 1'b1;
    run_div(4'd12, 4'd5, q, r, z, lat);
    n_checks++;
    if (lat != 5 || q !== 4'd2 || r !== 4'd2)
      $display("FAIL midreset_after got q=%0d r=%0d lat=%0d want q=2 r=2 lat=5", q, r, lat);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    int d0, d1, nd;
    logic [3:0] q, r;
    nd = 0;
    d0 = -1;
    d1 = -1;
    q = 'x;
    r = 'x;
    @(negedge clk);
    dividend_in = 4'd6;
    divisor_in  = 4'd2;
    start       = 1'b1;
    for (int k = 0; k < 20 && nd < 2; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (nd == 0) begin
          d0 = cyc;
          q = quotient_out;
          r = remainder_out;
        end else d1 = cyc;
        nd++;
      end
    end
    start = 1'b0;
    repeat (10) @(negedge clk);
    n_checks++; if (nd != 2 || (d1 - d0) != 6) $display("FAIL b2b_spacing got %0d pulses gap %0d want 2 gap 6", nd, d1 - d0); else n_pass++;
    n_checks++;
    if (q !== 4'd3 || r !== 4'd0)
      $display("FAIL b2b_result got q=%0d r=%0d want q=3 r=0", q, r);
    else n_pass++;
  endtask
`else
  task automatic test_signed;
    logic [3:0] vd [3] = '{4'b1001, 4'b0111, 4'b1000};
    logic [3:0] vs [3] = '{4'b0010, 4'b1110, 4'b1111};
    logic [3:0] eq [3] = '{4'b1101, 4'b1101, 4'b1000};
    logic [3:0] er [3] = '{4'b1111, 4'b0001, 4'b0000};
    logic [3:0] q, r;
    logic z;
    int lat;
    for (int i = 0; i < 3; i++) begin
      run_div(vd[i], vs[i], q, r, z, lat);
      n_checks++; if (lat != 5) $display("FAIL signed_lat_%0d got %0d want 5", i, lat); else n_pass++;
      n_checks++; if (q !== eq[i]) $display("FAIL signed_q_%0d got %b want %b", i, q, eq[i]); else n_pass++;
      n_checks++; if (r !== er[i] || z !== 1'b0) $display("FAIL signed_r_%0d got r=%b z=%b want r=%b z=0", i, r, z, er[i]); else n_pass++;
    end
    run_div(4'd9, 4'd0, q, r, z, lat);
    n_checks++;
    if (lat != 1 || q !== 4'hF || r !== 4'd9 || z !== 1'b1)
      $display("FAIL signed_dz got q=%h r=%0d z=%b lat=%0d want q=f r=9 z=1 lat=1", q, r, z, lat);
    else n_pass++;
  endtask
`endif

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend_in = '0;
    divisor_in  = '0;
    test_reset;
`ifndef SHIFT_SUB_SIGNED_EN
    test_basic;
    test_boundary;
    test_div_zero;
    test_busy_collision;
    test_reset_mid;
    test_back_to_back;
    test_sweep;
`else
    test_signed;
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
